// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A model: command-sequencer FSM states,
// ICW/OCW bit positions, OCW2 command encodings and the configuration
// register bundle held by the sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  // Command byte bit positions (A0=0 writes).
  localparam int ICW1_FLAG_BIT = 4;  // D4=1 marks ICW1
  localparam int OCW3_FLAG_BIT = 3;  // D3 distinguishes OCW3 (1) from OCW2 (0)
  localparam int OCW3_RIS_BIT  = 0;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_P_BIT    = 2;
  localparam int OCW3_SMM_BIT  = 5;
  localparam int OCW3_ESMM_BIT = 6;

  // OCW2 R/SL/EOI encodings, shared with the priority resolver.
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  // Everything the sequencer programs from ICWs and OCW1/OCW3.
  typedef struct packed {
    logic       ltim;
    logic       sngl;
    logic       ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       sfnm;
    logic       buf_en;
    logic       ms;
    logic       aeoi;
    logic       upm;
    logic [7:0] imr;
    logic       read_isr;
    logic       smm;
  } pic_cfg_t;

endpackage

// File: rtl/pic_write_detect.sv
// CPU write capture. Registers the write-active condition, latches data and
// A0 on every cycle the write is active, and emits a one-cycle write event
// (we_o) after the clock edge that first sees the write gone.
//   clk, reset_bar        clock, async active-low reset
//   chip_select_bar_i,
//   write_bar_i, a0_i,
//   data_i                raw CPU bus inputs
//   we_o                  one-cycle write event
//   a0_o, data_o          A0/data of the last active write cycle
module pic_write_detect
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       chip_select_bar_i,
  input  logic       write_bar_i,
  input  logic       a0_i,
  input  logic [7:0] data_i,
  output logic       we_o,
  output logic       a0_o,
  output logic [7:0] data_o
);

  logic       wr_act;
  logic       wr_act_q;
  logic       we_q;
  logic       a0_q;
  logic [7:0] data_q;

  assign wr_act = ~chip_select_bar_i & ~write_bar_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_act_q <= 1'b0;
      we_q     <= 1'b0;
      a0_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      wr_act_q <= wr_act;
      // Falling edge of wr_act: the write just ended. Clearing wr_act_q in
      // reset is what discards a write that was in flight.
      we_q     <= wr_act_q & ~wr_act;
      if (wr_act) begin
        a0_q   <= a0_i;
        data_q <= data_i;
      end
    end
  end

  assign we_o   = we_q;
  assign a0_o   = a0_q;
  assign data_o = data_q;

endmodule

// File: rtl/pic_command_sequencer.sv
// 8259A command sequencer. Turns completed CPU writes into ICW/OCW commands,
// walks the ICW1..ICW4 initialization sequence, holds configuration and the
// interrupt mask, pulses OCW2/poll strobes and drives the status read mux.
//   clk, reset_bar                       clock, async active-low reset
//   chip_select_bar, write_bar,
//   read_bar, A0, data_in                CPU bus
//   irr, isr                             live vectors for status reads
//   data_out, data_out_en                read data and bus drive enable
//   init_done                            initialization complete (READY)
//   ltim..sfnm, vector_base, cascade_cfg ICW configuration
//   imr, read_isr, smm                   OCW1/OCW3 state
//   ocw2_strobe/cmd/level, poll_strobe   one-cycle command pulses
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] RESET_IMR = 8'h00
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       chip_select_bar,
  input  logic       write_bar,
  input  logic       read_bar,
  input  logic       A0,
  input  logic [7:0] data_in,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms,
  output logic       buf_en,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_strobe,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       poll_strobe,
  output logic       read_isr,
  output logic       smm
);

  logic       we;
  logic       wr_a0;
  logic [7:0] wr_data;

  pic_write_detect u_write_detect (
    .clk               (clk),
    .reset_bar         (reset_bar),
    .chip_select_bar_i (chip_select_bar),
    .write_bar_i       (write_bar),
    .a0_i              (A0),
    .data_i            (data_in),
    .we_o              (we),
    .a0_o              (wr_a0),
    .data_o            (wr_data)
  );

  pic_state_e state_q, state_d;
  pic_cfg_t   cfg_q, cfg_d;
  logic       ocw2_strobe_q, ocw2_strobe_d;
  logic       poll_strobe_q, poll_strobe_d;
  logic [2:0] ocw2_cmd_q, ocw2_cmd_d;
  logic [2:0] ocw2_level_q, ocw2_level_d;

  logic is_icw1, is_ocw3;
  assign is_icw1 = ~wr_a0 & wr_data[ICW1_FLAG_BIT];
  assign is_ocw3 = ~wr_a0 & ~wr_data[ICW1_FLAG_BIT] & wr_data[OCW3_FLAG_BIT];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    ocw2_strobe_d = 1'b0;
    poll_strobe_d = 1'b0;
    ocw2_cmd_d    = ocw2_cmd_q;
    ocw2_level_d  = ocw2_level_q;

    if (we) begin
      if (is_icw1) begin
        // ICW1 restarts initialization from any state.
        state_d       = ST_WAIT_ICW2;
        cfg_d.ltim    = wr_data[3];
        cfg_d.sngl    = wr_data[1];
        cfg_d.ic4     = wr_data[0];
        cfg_d.imr     = 8'h00;
        cfg_d.read_isr = 1'b0;
        cfg_d.smm     = 1'b0;
        if (!wr_data[0]) begin
          {cfg_d.sfnm, cfg_d.buf_en, cfg_d.ms, cfg_d.aeoi, cfg_d.upm} = 5'b0;
        end
      end else if (wr_a0) begin
        case (state_q)
          ST_WAIT_ICW2: begin
            cfg_d.vector_base = wr_data[7:3];
            if (!cfg_q.sngl)    state_d = ST_WAIT_ICW3;
            else if (cfg_q.ic4) state_d = ST_WAIT_ICW4;
            else                state_d = ST_READY;
          end
          ST_WAIT_ICW3: begin
            cfg_d.cascade_cfg = wr_data;
            state_d = cfg_q.ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: begin
            {cfg_d.sfnm, cfg_d.buf_en, cfg_d.ms, cfg_d.aeoi, cfg_d.upm} = wr_data[4:0];
            state_d = ST_READY;
          end
          ST_READY: cfg_d.imr = wr_data;
          default: ;  // UNINIT ignores A0=1 writes
        endcase
      end else if (state_q == ST_READY) begin
        if (is_ocw3) begin
          if (wr_data[OCW3_RR_BIT])   cfg_d.read_isr = wr_data[OCW3_RIS_BIT];
          if (wr_data[OCW3_ESMM_BIT]) cfg_d.smm      = wr_data[OCW3_SMM_BIT];
          poll_strobe_d = wr_data[OCW3_P_BIT];
        end else begin
          ocw2_strobe_d = 1'b1;
          ocw2_cmd_d    = wr_data[7:5];
          ocw2_level_d  = wr_data[2:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q       <= ST_UNINIT;
      cfg_q         <= '0;
      cfg_q.imr     <= RESET_IMR;
      ocw2_strobe_q <= 1'b0;
      poll_strobe_q <= 1'b0;
      ocw2_cmd_q    <= 3'b000;
      ocw2_level_q  <= 3'b000;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      ocw2_strobe_q <= ocw2_strobe_d;
      poll_strobe_q <= poll_strobe_d;
      ocw2_cmd_q    <= ocw2_cmd_d;
      ocw2_level_q  <= ocw2_level_d;
    end
  end

  assign init_done   = (state_q == ST_READY);
  assign ltim        = cfg_q.ltim;
  assign sngl        = cfg_q.sngl;
  assign ic4         = cfg_q.ic4;
  assign vector_base = cfg_q.vector_base;
  assign cascade_cfg = cfg_q.cascade_cfg;
  assign upm         = cfg_q.upm;
  assign aeoi        = cfg_q.aeoi;
  assign ms          = cfg_q.ms;
  assign buf_en      = cfg_q.buf_en;
  assign sfnm        = cfg_q.sfnm;
  assign imr         = cfg_q.imr;
  assign read_isr    = cfg_q.read_isr;
  assign smm         = cfg_q.smm;
  assign ocw2_strobe = ocw2_strobe_q;
  assign ocw2_cmd    = ocw2_cmd_q;
  assign ocw2_level  = ocw2_level_q;
  assign poll_strobe = poll_strobe_q;

  // Status read path; a simultaneous write keeps the buffer off the bus.
  assign data_out_en = ~chip_select_bar & ~read_bar & write_bar & init_done;
  assign data_out    = !data_out_en ? 8'h00 :
                       A0           ? cfg_q.imr :
                       cfg_q.read_isr ? isr : irr;

endmodule

// File: doc/pic_command_sequencer.md
# pic_command_sequencer

Clocked command sequencer for the 8259A model. It turns CPU write cycles into single-cycle command events and steps through the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence. It holds the resulting configuration and interrupt mask, and issues OCW strobes to the priority/ISR logic. It also drives the status read path, selecting IRR, ISR or IMR for the data bus buffer.

## Interface
- RESET_IMR, 8'h00, IMR value after reset
- clk  in  1  single system clock
- reset_bar  in  1  asynchronous, active-low reset
- chip_select_bar, write_bar, read_bar, A0  in  1 each  CPU bus controls, active-low except A0
- data_in  in  8  CPU write data
- irr, isr  in  8 each  live request/in-service vectors for reads
- data_out  out  8  read data
- data_out_en  out  1  drive enable for data bus buffer
- init_done  out  1  high in READY
- ltim, sngl, ic4  out  1 each  ICW1 D3, D1, D0
- vector_base  out  5  ICW2 D7:D3
- cascade_cfg  out  8  ICW3 byte
- upm, aeoi, ms, buf_en, sfnm  out  1 each  ICW4 D0, D1, D2, D3, D4
- imr  out  8  OCW1 mask
- ocw2_strobe  out  1  one-cycle pulse
- ocw2_cmd  out  3  R/SL/EOI (D7:D5), valid with strobe
- ocw2_level  out  3  L2:L0, valid with strobe
- poll_strobe  out  1  one-cycle pulse on OCW3 P=1
- read_isr  out  1  0 selects IRR, 1 selects ISR
- smm  out  1  special mask mode

## Operation
- Write capture: wr_act = ~chip_select_bar & ~write_bar, registered each clk. While wr_act=1, data_in and A0 are latched every cycle.
- Write event (WE): wr_act_q=1 and wr_act=0, i.e. the end of the write. The event uses the last latched data/A0.
- Decode on WE: A0=0 & D4=1 is ICW1. A0=0 & D4=0 & D3=0 is OCW2. A0=0 & D4=0 & D3=1 is OCW3. A0=1 is a sequence ICW or OCW1, depending on state.
- FSM states: UNINIT (reset), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 is accepted in any state:
  - next state WAIT_ICW2
  - latch ltim/sngl/ic4
  - imr←00, read_isr←0, smm←0
  - if D0=0, clear all ICW4 fields to 0
- WAIT_ICW2 + A0=1: vector_base←D7:D3. Next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW3 + A0=1: cascade_cfg←D. Next state is WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4 + A0=1: latch ICW4 fields (D7:D5 ignored). Next state READY.
- READY + A0=1: imr←D.
- READY + OCW2: one ocw2_strobe with ocw2_cmd=D7:D5 and ocw2_level=D2:D0.
- READY + OCW3:
  - if D1=1, read_isr←D0
  - if D6=1, smm←D5
  - if D2=1, one poll_strobe
- Ignored writes (no state or register change):
  - UNINIT: A0=1 writes and OCW2/3
  - WAIT_ICWx: OCW2/3
- Read path (combinational):
  - data_out_en = ~chip_select_bar & ~read_bar & write_bar & init_done
  - data_out = A0 ? imr : (read_isr ? isr : irr)
  - data_out = 8'h00 when data_out_en=0
- Reset values: state UNINIT; init_done, ltim, sngl, ic4, all ICW4 fields, read_isr, smm, strobes all 0; vector_base 0; cascade_cfg 00; imr RESET_IMR; data_out_en 0.

## Timing
- WE is detected on the first clk edge that samples wr_act=0 after ≥1 cycle at 1.
- Registers, state and strobes update on the next edge, so latency is 1 clk from WE detection.
- A write shorter than one clk period may be missed. Bus writes must span ≥2 clk edges.
- Strobes are exactly 1 cycle. Back-to-back writes each produce their own strobe.
- init_done rises the cycle after the final ICW commits. It falls the cycle after ICW1 commits.
- Read and write asserted together: write is captured; data_out_en=0.
- chip_select_bar deasserted mid-write ends wr_act and generates WE.
- reset_bar low at any point, including mid-sequence or mid-write: immediate return to reset values. The pending write is discarded, with no WE after release.

## Structure
- Shared package pic_pkg holds:
  - FSM state encodings
  - ICW/OCW bit-position localparams (D4 ICW1 flag, D3 OCW3 flag, RR/RIS/P/ESMM/SMM)
  - ocw2_cmd encodings, reused by the priority resolver
- One sub-module, pic_write_detect: wr_act register, data/A0 latch, WE pulse generation.
- FSM, config registers and read mux stay in the top.

## Test plan
- ICW1=8'h13 (sngl, ic4), ICW2=8'h40, ICW4=8'h03 → vector_base=5'h08, upm=1, aeoi=1, init_done high 1 clk after ICW4 WE; WAIT_ICW3 skipped.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 → cascade_cfg=04, state passes WAIT_ICW3; then OCW1=8'hA5 → imr=A5; read with A0=1 → data_out=A5.
- In READY: OCW2=8'h63 → one-cycle ocw2_strobe, ocw2_cmd=3'b011, ocw2_level=3; OCW3=8'h0B then A0=0 read with isr=8'h10 → data_out=10; OCW3=8'h0C → poll_strobe pulse.
- Before init: OCW1=8'hFF and OCW2 writes → imr, strobes and state unchanged; data_out_en=0 on read.
- Mid-sequence (after ICW2): new ICW1=8'h12 → back to WAIT_ICW2, imr=00, ICW4 fields=0; after ICW2 → READY directly.
- reset_bar pulsed low while write active and in WAIT_ICW3 → all outputs at reset values immediately, no strobe after release.
